// File: rtl/bitbrick_mac_pe.sv
// Bit-brick PE: NUM_BRICKS 2x2-bit products, summed and shifted, then
// fed to a 2-stage grouped accumulator with saturation and overflow flag.
module bitbrick_mac_pe #(
    parameter int NUM_BRICKS = 16,
    parameter int MAX_SHIFT  = 6,
    parameter int ACC_W      = 24,
    parameter int SATURATE   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    input  logic                      i_first,
    input  logic                      i_last,
    input  logic [2*NUM_BRICKS-1:0]   i_activation,
    input  logic [2*NUM_BRICKS-1:0]   i_weight,
    input  logic                      i_A_signed,
    input  logic                      i_W_signed,
    input  logic [3:0]                i_shift_amount,
    output logic                      o_valid,
    output logic signed [ACC_W-1:0]   o_acc,
    output logic                      o_ovf
);

    localparam int SUM_W = 5 + $clog2(NUM_BRICKS);
    localparam int PW    = SUM_W + MAX_SHIFT;
    // Headroom so p and acc both fit and their sum cannot wrap.
    localparam int EW    = ((PW > ACC_W) ? PW : ACC_W) + 2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [4:0]       prod [NUM_BRICKS];
    logic signed [SUM_W-1:0] brick_sum;
    logic [3:0]              sh;
    logic signed [PW-1:0]    p_d;

    for (genvar g = 0; g < NUM_BRICKS; g++) begin : g_brick
        logic signed [4:0] a_x;
        logic signed [4:0] w_x;
        assign a_x = {{3{i_A_signed & i_activation[2*g+1]}},
                      i_activation[2*g +: 2]};
        assign w_x = {{3{i_W_signed & i_weight[2*g+1]}},
                      i_weight[2*g +: 2]};
        assign prod[g] = a_x * w_x;
    end

    always_comb begin
        brick_sum = '0;
        for (int k = 0; k < NUM_BRICKS; k++) begin
            brick_sum = brick_sum + SUM_W'(prod[k]);
        end
    end

    assign sh  = (i_shift_amount <= 4'(MAX_SHIFT)) ? i_shift_amount : 4'd0;
    assign p_d = PW'(brick_sum) <<< sh;

    logic                    v1_q, f1_q, l1_q;
    logic signed [PW-1:0]    p_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    ovf_q;
    logic                    closed_q;

    logic                    start;
    logic signed [EW-1:0]    base;
    logic signed [EW-1:0]    sum_w;
    logic                    ovf_beat;
    logic signed [ACC_W-1:0] acc_d;
    logic                    grp_ovf_d;

    always_comb begin
        start    = f1_q | closed_q;
        base     = start ? '0 : EW'(acc_q);
        sum_w    = base + EW'(p_q);
        ovf_beat = (sum_w > EW'(ACC_MAX)) || (sum_w < EW'(ACC_MIN));
        acc_d    = sum_w[ACC_W-1:0];
        if ((SATURATE != 0) && ovf_beat) begin
            acc_d = sum_w[EW-1] ? ACC_MIN : ACC_MAX;
        end
        grp_ovf_d = (~start & ovf_q) | ovf_beat;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q     <= 1'b0;
            f1_q     <= 1'b0;
            l1_q     <= 1'b0;
            p_q      <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            closed_q <= 1'b1;
            o_valid  <= 1'b0;
            o_acc    <= '0;
            o_ovf    <= 1'b0;
        end else begin
            v1_q    <= i_valid;
            f1_q    <= i_valid & i_first;
            l1_q    <= i_valid & i_last;
            if (i_valid) p_q <= p_d;
            o_valid <= v1_q & l1_q;
            if (v1_q) begin
                acc_q    <= acc_d;
                ovf_q    <= grp_ovf_d;
                closed_q <= l1_q;
                if (l1_q) begin
                    o_acc <= acc_d;
                    o_ovf <= grp_ovf_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitbrick_mac_pe.sv
// Bench for bitbrick_mac_pe: vector table, corner sequences and random
// beats against an integer group model, on three width/saturation configs.
module tb_bitbrick_mac_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, first, last, a_s, w_s;
    logic [31:0] act, wgt;
    logic [3:0]  shamt;

    logic        v0, v1, v2;
    logic [23:0] acc0;
    logic [11:0] acc1, acc2;
    logic        ovf0, ovf1, ovf2;

    always #5 clk = ~clk;

    bitbrick_mac_pe #(.ACC_W(24), .SATURATE(1)) u_d24 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_first(first),
        .i_last(last), .i_activation(act), .i_weight(wgt),
        .i_A_signed(a_s), .i_W_signed(w_s), .i_shift_amount(shamt),
        .o_valid(v0), .o_acc(acc0), .o_ovf(ovf0));

    bitbrick_mac_pe #(.ACC_W(12), .SATURATE(1)) u_d12s (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_first(first),
        .i_last(last), .i_activation(act), .i_weight(wgt),
        .i_A_signed(a_s), .i_W_signed(w_s), .i_shift_amount(shamt),
        .o_valid(v1), .o_acc(acc1), .o_ovf(ovf1));

    bitbrick_mac_pe #(.ACC_W(12), .SATURATE(0)) u_d12w (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_first(first),
        .i_last(last), .i_activation(act), .i_weight(wgt),
        .i_A_signed(a_s), .i_W_signed(w_s), .i_shift_amount(shamt),
        .o_valid(v2), .o_acc(acc2), .o_ovf(ovf2));

    typedef struct {
        logic        v, f, l, as, ws;
        logic [31:0] a, w;
        logic [3:0]  sh;
    } beat_t;

    typedef struct {
        int     due;
        longint acc [3];
        logic   ovf [3];
    } exp_t;

    typedef struct {
        beat_t  b;
        longint e24, e12s, e12w;
        logic   o24, o12;
    } vec_t;

    int     n_err = 0;
    int     n_chk = 0;
    int     edge_n = 0;
    exp_t   q[$];
    longint m_acc [3];
    logic   m_ovf [3];
    logic   m_closed [3];
    longint last_acc [3];
    logic   last_ovf [3];
    int     cw [3] = '{24, 12, 12};
    bit     csat [3] = '{1'b1, 1'b1, 1'b0};
    beat_t  idle;
    vec_t   tbl [4];

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     nm, got, exp, edge_n);
        end
    endtask

    function automatic longint brick_p(input beat_t b);
        longint s = 0;
        int     a, w, k;
        for (k = 0; k < 16; k++) begin
            a = int'((b.a >> (2 * k)) & 32'd3);
            w = int'((b.w >> (2 * k)) & 32'd3);
            if (b.as && a >= 2) a -= 4;
            if (b.ws && w >= 2) w -= 4;
            s += longint'(a * w);
        end
        if (b.sh <= 4'd6) s = s * (longint'(1) << b.sh);
        return s;
    endfunction

    function automatic longint sx(input longint x, input int w);
        longint m = (longint'(1) << w) - 1;
        longint t = x & m;
        if (t >= (longint'(1) << (w - 1))) t -= (longint'(1) << w);
        return t;
    endfunction

    task automatic model_beat(input beat_t b);
        longint p = brick_p(b);
        longint mx, mn, s;
        bit     st, ob;
        exp_t   e;
        e.due = edge_n + 1;
        for (int c = 0; c < 3; c++) begin
            mx = (longint'(1) << (cw[c] - 1)) - 1;
            mn = -(longint'(1) << (cw[c] - 1));
            st = b.f || m_closed[c];
            s  = st ? p : m_acc[c] + p;
            ob = (s > mx) || (s < mn);
            if (ob) s = csat[c] ? ((s > mx) ? mx : mn) : sx(s, cw[c]);
            m_acc[c]    = s;
            m_ovf[c]    = (st ? 1'b0 : m_ovf[c]) | ob;
            m_closed[c] = b.l;
            e.acc[c]    = s;
            e.ovf[c]    = m_ovf[c];
        end
        if (b.l) q.push_back(e);
    endtask

    task automatic check_outs();
        bit   ev;
        exp_t e;
        ev = (q.size() > 0) && (q[0].due == edge_n);
        if (ev) begin
            e = q.pop_front();
            for (int c = 0; c < 3; c++) begin
                last_acc[c] = e.acc[c];
                last_ovf[c] = e.ovf[c];
            end
        end
        chk("valid24", longint'(v0), longint'(ev));
        chk("valid12s", longint'(v1), longint'(ev));
        chk("valid12w", longint'(v2), longint'(ev));
        chk("acc24", longint'($signed(acc0)), last_acc[0]);
        chk("acc12s", longint'($signed(acc1)), last_acc[1]);
        chk("acc12w", longint'($signed(acc2)), last_acc[2]);
        chk("ovf24", longint'(ovf0), longint'(last_ovf[0]));
        chk("ovf12s", longint'(ovf1), longint'(last_ovf[1]));
        chk("ovf12w", longint'(ovf2), longint'(last_ovf[2]));
    endtask

    task automatic step(input beat_t b, input logic r);
        rst   = r;
        valid = b.v;
        first = b.f;
        last  = b.l;
        act   = b.a;
        wgt   = b.w;
        a_s   = b.as;
        w_s   = b.ws;
        shamt = b.sh;
        @(posedge clk);
        edge_n++;
        if (r) begin
            q.delete();
            for (int c = 0; c < 3; c++) begin
                m_acc[c] = 0; m_ovf[c] = 1'b0; m_closed[c] = 1'b1;
                last_acc[c] = 0; last_ovf[c] = 1'b0;
            end
        end else if (b.v) begin
            model_beat(b);
        end
        #1;
        check_outs();
    endtask

    function automatic beat_t mk(input logic [31:0] a, input logic [31:0] w,
                                 input logic as, input logic ws,
                                 input logic [3:0] sh,
                                 input logic f, input logic l);
        beat_t b;
        b.v = 1'b1; b.f = f; b.l = l; b.a = a; b.w = w;
        b.as = as; b.ws = ws; b.sh = sh;
        return b;
    endfunction

    beat_t b11;
    beat_t rb;

    initial begin
        idle = '{v: 1'b0, f: 1'b0, l: 1'b0, as: 1'b0, ws: 1'b0,
                 a: 32'd0, w: 32'd0, sh: 4'd0};
        for (int c = 0; c < 3; c++) begin
            m_acc[c] = 0; m_ovf[c] = 1'b0; m_closed[c] = 1'b1;
            last_acc[c] = 0; last_ovf[c] = 1'b0;
        end
        tbl[0] = '{mk(32'h5555_5555, 32'h5555_5555, 1, 1, 0, 1, 1),
                   16, 16, 16, 1'b0, 1'b0};
        tbl[1] = '{mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 6, 1, 1),
                   9216, 2047, 1024, 1'b0, 1'b1};
        tbl[2] = '{mk(32'hAAAA_AAAA, 32'hFFFF_FFFF, 1, 0, 2, 1, 1),
                   -384, -384, -384, 1'b0, 1'b0};
        tbl[3] = '{mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 7, 1, 1),
                   144, 144, 144, 1'b0, 1'b0};

        step(idle, 1'b1);
        step(idle, 1'b1);
        chk("rst_valid", longint'(v0), 0);
        chk("rst_acc", longint'($signed(acc0)), 0);

        foreach (tbl[i]) begin
            step(tbl[i].b, 1'b0);
            step(idle, 1'b0);
            chk($sformatf("tbl%0d_valid", i), longint'(v0), 1);
            chk($sformatf("tbl%0d_acc24", i), longint'($signed(acc0)), tbl[i].e24);
            chk($sformatf("tbl%0d_acc12s", i), longint'($signed(acc1)), tbl[i].e12s);
            chk($sformatf("tbl%0d_acc12w", i), longint'($signed(acc2)), tbl[i].e12w);
            chk($sformatf("tbl%0d_ovf24", i), longint'(ovf0), longint'(tbl[i].o24));
            chk($sformatf("tbl%0d_ovf12", i), longint'(ovf1), longint'(tbl[i].o12));
        end

        // 3-beat group with a bubble, then a fresh group without i_first.
        b11 = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2, 1, 0);
        step(b11, 1'b0);
        b11.f = 1'b0;
        step(b11, 1'b0);
        step(idle, 1'b0);
        b11.l = 1'b1;
        step(b11, 1'b0);
        step(mk(32'h5555_5555, 32'h5555_5555, 1, 1, 0, 0, 1), 1'b0);
        chk("grp3_valid", longint'(v0), 1);
        chk("grp3_acc", longint'($signed(acc0)), 1728);
        step(idle, 1'b0);
        chk("fresh_valid", longint'(v0), 1);
        chk("fresh_acc", longint'($signed(acc0)), 16);
        step(idle, 1'b0);
        chk("hold_valid", longint'(v0), 0);
        chk("hold_acc", longint'($signed(acc0)), 16);

        // Reset one cycle after a last beat kills its output.
        step(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 6, 1, 1), 1'b0);
        step(idle, 1'b1);
        step(idle, 1'b0);
        chk("rstkill_valid", longint'(v0), 0);
        chk("rstkill_acc", longint'($signed(acc0)), 0);
        step(mk(32'h5555_5555, 32'h5555_5555, 1, 1, 0, 1, 1), 1'b0);
        step(idle, 1'b0);
        chk("postrst_acc", longint'($signed(acc0)), 16);

        // Mid-group i_first abandons the partial sum.
        step(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 6, 1, 0), 1'b0);
        step(mk(32'h5555_5555, 32'h5555_5555, 1, 1, 0, 1, 0), 1'b0);
        step(mk(32'h5555_5555, 32'h5555_5555, 1, 1, 1, 0, 1), 1'b0);
        step(idle, 1'b0);
        chk("restart_acc", longint'($signed(acc0)), 48);
        chk("restart_ovf12", longint'(ovf1), 0);

        for (int n = 0; n < 600; n++) begin
            rb.v  = ($urandom % 4) != 0;
            rb.f  = ($urandom % 5) == 0;
            rb.l  = ($urandom % 4) == 0;
            rb.a  = $urandom;
            rb.w  = $urandom;
            rb.as = $urandom % 2;
            rb.ws = $urandom % 2;
            rb.sh = 4'($urandom % 16);
            step(rb, ($urandom % 80) == 0);
        end
        step(idle, 1'b0);
        step(idle, 1'b0);
        chk("queue_drained", longint'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
